// File: rtl/dm_write_monitor_pkg.sv
// Shared definitions for the DM write monitor.
//   state_t     : monitor FSM encoding (also exported on dbg_state)
//   FC_*        : fail_code values reported on a failed check
package dm_write_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_DONE_PASS = 2'd2,
        ST_DONE_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_DATA    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

endpackage

// File: rtl/dm_wm_timeout.sv
// Saturating idle-cycle counter for the DM write monitor.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the counter (has priority over en)
//   en       : count this cycle
//   limit    : expiry threshold, 0 disables expiry
//   cnt      : current count
//   expire   : high on the cycle whose increment makes cnt reach limit
module dm_wm_timeout #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic [TO_W-1:0] cnt,
    output logic            expire
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            // Saturate instead of wrapping so a stale count never looks fresh.
            cnt <= cnt + TO_W'(1);
        end
    end

    // Flag expiry on the edge where the count would reach limit, so the
    // owner can leave its armed state on that same edge.
    assign expire = en && (limit != '0) && (cnt >= (limit - TO_W'(1)));

endmodule

// File: rtl/dm_write_monitor.sv
// Data-memory write checker. Snoops the DM write port and matches writes
// against a table of expected (address, mask, data) entries, in index order
// or in any order, with a watchdog on idle cycles between matches.
//   cfg_we/cfg_idx/cfg_addr/cfg_mask/cfg_data : table write (dropped while busy)
//   n_exp, ordered                            : sampled on start
//   to_limit                                  : idle cycles allowed, 0 = none
//   start                                     : arm / re-arm pulse
//   we_dm, A_dm, write_data_dm                : snooped DM write port
//   busy, pass, fail, fail_code, match_cnt    : status (pass/fail sticky)
//   fail_addr, fail_data                      : offending write (0 on timeout)
//   dbg_state                                 : FSM state for observation
//
// Handshake: none; every snooped write with we_dm high on a clock edge while
// busy is a complete transaction, there is no back-pressure.
module dm_write_monitor
    import dm_write_monitor_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_CHK  = 4,
    parameter int TO_W   = 16,
    localparam int IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1,
    localparam int CNT_W = $clog2(N_CHK + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CNT_W-1:0]  n_exp,
    input  logic              ordered,
    input  logic [TO_W-1:0]   to_limit,
    input  logic              start,
    input  logic              we_dm,
    input  logic [ADDR_W-1:0] A_dm,
    input  logic [DATA_W-1:0] write_data_dm,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [1:0]        dbg_state
);

    logic [ADDR_W-1:0] tbl_addr [N_CHK];
    logic [ADDR_W-1:0] tbl_mask [N_CHK];
    logic [DATA_W-1:0] tbl_data [N_CHK];
    logic [N_CHK-1:0]  hit_q;
    logic [N_CHK-1:0]  addr_hit;
    logic [CNT_W-1:0]  n_exp_q;
    logic              ordered_q;
    state_t            state_q, state_d;

    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic              check, match, mism, to_expire, to_en;
    logic [CNT_W-1:0]  new_cnt;
    logic [TO_W-1:0]   to_cnt;

    assign busy      = (state_q == ST_ARMED);
    assign dbg_state = state_q;

    // Table: a write in the same cycle as start lands on that edge, so the
    // new entry is already in effect for the first checked write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CHK; i++) begin
                tbl_addr[i] <= '0;
                tbl_mask[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (cfg_we && !busy) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_mask[cfg_idx] <= cfg_mask;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    for (genvar g = 0; g < N_CHK; g++) begin : g_cmp
        assign addr_hit[g] = ((A_dm & tbl_mask[g]) == (tbl_addr[g] & tbl_mask[g]));
    end

    // Ordered: only entry match_cnt is eligible. Unordered: lowest-index
    // in-use entry not yet hit; the descending loop lets the lowest win.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (ordered_q) begin
            for (int i = 0; i < N_CHK; i++) begin
                if ((CNT_W'(i) == match_cnt) && addr_hit[i]) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = N_CHK - 1; i >= 0; i--) begin
                if (!hit_q[i] && addr_hit[i] && (CNT_W'(i) < n_exp_q)) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
    end

    // start outranks a coincident write: that write is never checked.
    assign check   = busy && we_dm && !start;
    assign match   = check && sel_valid && (write_data_dm == tbl_data[sel_idx]);
    assign mism    = check && sel_valid && (write_data_dm != tbl_data[sel_idx]);
    assign new_cnt = match_cnt + CNT_W'(1);
    assign to_en   = busy && !start && !match && (to_limit != '0);

    dm_wm_timeout #(.TO_W(TO_W)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (start || match),
        .en     (to_en),
        .limit  (to_limit),
        .cnt    (to_cnt),
        .expire (to_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (n_exp == '0) ? ST_DONE_PASS : ST_ARMED;
        end else if (state_q == ST_ARMED) begin
            // A match on the expiry cycle wins over the timeout.
            if (match) begin
                if (new_cnt == n_exp_q) begin
                    state_d = ST_DONE_PASS;
                end
            end else if (mism || to_expire) begin
                state_d = ST_DONE_FAIL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            hit_q     <= '0;
            n_exp_q   <= '0;
            ordered_q <= 1'b0;
        end else if (start) begin
            pass      <= (n_exp == '0);
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            hit_q     <= '0;
            n_exp_q   <= n_exp;
            ordered_q <= ordered;
        end else if (busy) begin
            if (match) begin
                hit_q[sel_idx] <= 1'b1;
                match_cnt      <= new_cnt;
                if (new_cnt == n_exp_q) begin
                    pass <= 1'b1;
                end
            end else if (mism) begin
                fail      <= 1'b1;
                fail_code <= FC_DATA;
                fail_addr <= A_dm;
                fail_data <= write_data_dm;
            end else if (to_expire) begin
                fail      <= 1'b1;
                fail_code <= FC_TIMEOUT;
                fail_addr <= '0;
                fail_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dm_write_monitor.sv
module tb_dm_write_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_mask = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  n_exp = '0;
    logic        ordered = 1'b0;
    logic [15:0] to_limit = '0;
    logic        start = 1'b0;
    logic        we_dm = 1'b0;
    logic [31:0] A_dm = '0;
    logic [31:0] write_data_dm = '0;
    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [2:0]  match_cnt;
    logic [31:0] fail_addr, fail_data;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    dm_write_monitor dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data),
        .n_exp(n_exp), .ordered(ordered), .to_limit(to_limit), .start(start),
        .we_dm(we_dm), .A_dm(A_dm), .write_data_dm(write_data_dm),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog expired");
    end

    // checking
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drivers: inputs change 1 time unit after posedge, outputs sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_entry(input logic [1:0] idx, input logic [31:0] a,
                             input logic [31:0] m, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_mask = m; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] n, input logic ord, input logic [15:0] lim);
        start = 1'b1; n_exp = n; ordered = ord; to_limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic dm_write(input logic [31:0] a, input logic [31:0] d);
        we_dm = 1'b1; A_dm = a; write_data_dm = d;
        tick();
        we_dm = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_code", fail_code, 0);
        chk("rst_mcnt", match_cnt, 0);
        chk("rst_faddr", fail_addr, 0);
        chk("rst_fdata", fail_data, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // legacy single pattern: 0x64 & 7 == 4
        cfg_entry(2'd0, 32'h4, 32'h7, 32'h7);
        do_start(3'd1, 1'b1, 16'd0);
        chk("leg_busy", busy, 1);
        chk("leg_state", dbg_state, 1);
        dm_write(32'h64, 32'h7);
        chk("leg_pass", pass, 1);
        chk("leg_mcnt", match_cnt, 1);
        chk("leg_fail", fail, 0);
        chk("leg_busy_after", busy, 0);

        // ordered
        cfg_entry(2'd0, 32'h10, 32'hFFFF_FFFF, 32'hA);
        cfg_entry(2'd1, 32'h14, 32'hFFFF_FFFF, 32'hB);
        cfg_entry(2'd2, 32'h18, 32'hFFFF_FFFF, 32'hC);
        do_start(3'd3, 1'b1, 16'd0);
        chk("ord_start_clr_pass", pass, 0);
        dm_write(32'h14, 32'hB);
        chk("ord_skip_mcnt", match_cnt, 0);
        chk("ord_skip_fail", fail, 0);
        dm_write(32'h10, 32'hA);
        chk("ord_m1", match_cnt, 1);
        dm_write(32'h14, 32'hB);
        chk("ord_m2", match_cnt, 2);
        chk("ord_m2_pass", pass, 0);
        dm_write(32'h18, 32'hC);
        chk("ord_m3", match_cnt, 3);
        chk("ord_pass", pass, 1);

        // unordered
        do_start(3'd3, 1'b0, 16'd0);
        dm_write(32'h18, 32'hC);
        chk("uno_m1", match_cnt, 1);
        chk("uno_m1_pass", pass, 0);
        dm_write(32'h10, 32'hA);
        chk("uno_m2", match_cnt, 2);
        dm_write(32'h14, 32'hB);
        chk("uno_m3", match_cnt, 3);
        chk("uno_pass", pass, 1);
        chk("uno_fail", fail, 0);

        // data mismatch
        cfg_entry(2'd0, 32'h20, 32'hFFFF_FFFF, 32'h55);
        do_start(3'd1, 1'b1, 16'd0);
        dm_write(32'h20, 32'h56);
        chk("mis_fail", fail, 1);
        chk("mis_code", fail_code, 1);
        chk("mis_faddr", fail_addr, 32'h20);
        chk("mis_fdata", fail_data, 32'h56);
        chk("mis_pass", pass, 0);
        chk("mis_state", dbg_state, 3);

        // timeout: fail visible exactly 5 cycles after busy rises
        do_start(3'd1, 1'b1, 16'd5);
        chk("to_busy", busy, 1);
        chk("to_start_clr_fail", fail, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("to_early_fail", fail, 0);
        tick();
        chk("to_fail", fail, 1);
        chk("to_code", fail_code, 2);
        chk("to_faddr", fail_addr, 0);
        chk("to_fdata", fail_data, 0);

        // match on the expiry cycle wins
        do_start(3'd1, 1'b1, 16'd5);
        for (int i = 0; i < 4; i++) tick();
        dm_write(32'h20, 32'h55);
        chk("tom_pass", pass, 1);
        chk("tom_fail", fail, 0);
        chk("tom_code", fail_code, 0);

        // cfg_we while busy is dropped
        do_start(3'd1, 1'b1, 16'd0);
        cfg_entry(2'd0, 32'h30, 32'hFFFF_FFFF, 32'h99);
        dm_write(32'h20, 32'h55);
        chk("cfgbusy_pass", pass, 1);
        chk("cfgbusy_fail", fail, 0);

        // cfg_we together with start: new entry in effect
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'h40; cfg_mask = 32'hFFFF_FFFF; cfg_data = 32'h11;
        do_start(3'd1, 1'b1, 16'd0);
        cfg_we = 1'b0;
        dm_write(32'h40, 32'h11);
        chk("cfgstart_pass", pass, 1);

        // start and write in the same cycle: the write is not checked
        start = 1'b1; n_exp = 3'd1; ordered = 1'b1; to_limit = 16'd0;
        we_dm = 1'b1; A_dm = 32'h40; write_data_dm = 32'h11;
        tick();
        start = 1'b0; we_dm = 1'b0;
        chk("stw_mcnt", match_cnt, 0);
        chk("stw_pass", pass, 0);
        chk("stw_busy", busy, 1);

        // n_exp = 0
        do_start(3'd0, 1'b1, 16'd0);
        chk("n0_pass", pass, 1);
        chk("n0_busy", busy, 0);

        // reset mid-ARMED clears outputs and table
        do_start(3'd1, 1'b1, 16'd0);
        chk("rstm_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("rstm_busy", busy, 0);
        chk("rstm_state", dbg_state, 0);
        chk("rstm_pass", pass, 0);
        chk("rstm_fail", fail, 0);
        tick();
        rst = 1'b0;
        tick();
        // cleared entry0 has mask 0 and data 0, so any address with data 0 matches
        do_start(3'd1, 1'b1, 16'd0);
        dm_write(32'h1234, 32'h0);
        chk("rstm_tbl_pass", pass, 1);
        chk("rstm_tbl_fail", fail, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
